// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word on a valid/ready handshake and
// emits it one bit per slot with a direction-specific shift strobe for the receiving register.
module word_serializer #(
    parameter int WIDTH = 16,
    parameter int GAP   = 0
) (
    input  logic             Clock,
    input  logic             DoReset,
    input  logic [WIDTH-1:0] InData,
    input  logic             InValid,
    output logic             InReady,
    input  logic             InMSBFirst,
    output logic             SerialBit,
    output logic             ShiftR2L,
    output logic             ShiftL2R,
    output logic             Busy,
    output logic             Done
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bitcnt;
    logic [GW-1:0]    r_gapcnt;
    logic             r_msb_first;
    logic             r_ready;
    logic             r_serial;
    logic             r_r2l;
    logic             r_l2r;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_shifted;
    logic             w_in_bit;
    logic             w_shift_bit;
    logic             w_hold_bit;

    // The outgoing end of the register is always presented, so the shift runs toward it.
    assign w_shifted   = r_msb_first ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
    assign w_in_bit    = InMSBFirst  ? InData[WIDTH-1]    : InData[0];
    assign w_shift_bit = r_msb_first ? w_shifted[WIDTH-1] : w_shifted[0];
    assign w_hold_bit  = r_msb_first ? r_shreg[WIDTH-1]   : r_shreg[0];

    // Outputs are registered alongside the state so they depend on registered state only.
    always_ff @(posedge Clock) begin
        if (DoReset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_gapcnt    <= '0;
            r_msb_first <= 1'b0;
            r_ready     <= 1'b1;
            r_serial    <= 1'b0;
            r_r2l       <= 1'b0;
            r_l2r       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (InValid) begin
                        r_state     <= S_SHIFT;
                        r_shreg     <= InData;
                        r_msb_first <= InMSBFirst;
                        r_bitcnt    <= '0;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_serial    <= w_in_bit;
                        r_r2l       <= InMSBFirst;
                        r_l2r       <= ~InMSBFirst;
                    end
                end
                S_SHIFT: begin
                    r_shreg  <= w_shifted;
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (r_bitcnt == LAST_BIT) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_serial <= 1'b0;
                        r_r2l    <= 1'b0;
                        r_l2r    <= 1'b0;
                    end else if (GAP > 0) begin
                        r_state  <= S_GAP;
                        r_gapcnt <= GAP_LOAD;
                        r_serial <= 1'b0;
                        r_r2l    <= 1'b0;
                        r_l2r    <= 1'b0;
                    end else begin
                        r_serial <= w_shift_bit;
                    end
                end
                S_GAP: begin
                    if (r_gapcnt == '0) begin
                        r_state  <= S_SHIFT;
                        r_serial <= w_hold_bit;
                        r_r2l    <= r_msb_first;
                        r_l2r    <= ~r_msb_first;
                    end else begin
                        r_gapcnt <= r_gapcnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign InReady   = r_ready;
    assign SerialBit = r_serial;
    assign ShiftR2L  = r_r2l;
    assign ShiftL2R  = r_l2r;
    assign Busy      = r_busy;
    assign Done      = r_done;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: two instances (GAP=0 and GAP=2) checked cycle by cycle against
// a slot-timing model and a model receiver that reassembles the word from the strobes.
module tb_word_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data;
    logic         msbf;
    logic         valid0, valid2;
    logic         rdy0, ser0, r2l0, l2r0, busy0, done0;
    logic         rdy2, ser2, r2l2, l2r2, busy2, done2;

    int n_cmp  = 0;
    int n_fail = 0;
    int sel    = 0;

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(W), .GAP(0)) dut0 (
        .Clock(clk), .DoReset(rst), .InData(data), .InValid(valid0), .InReady(rdy0),
        .InMSBFirst(msbf), .SerialBit(ser0), .ShiftR2L(r2l0), .ShiftL2R(l2r0),
        .Busy(busy0), .Done(done0)
    );

    word_serializer #(.WIDTH(W), .GAP(2)) dut2 (
        .Clock(clk), .DoReset(rst), .InData(data), .InValid(valid2), .InReady(rdy2),
        .InMSBFirst(msbf), .SerialBit(ser2), .ShiftR2L(r2l2), .ShiftL2R(l2r2),
        .Busy(busy2), .Done(done2)
    );

    logic obs_ready, obs_ser, obs_r2l, obs_l2r, obs_busy, obs_done;
    assign obs_ready = (sel == 2) ? rdy2  : rdy0;
    assign obs_ser   = (sel == 2) ? ser2  : ser0;
    assign obs_r2l   = (sel == 2) ? r2l2  : r2l0;
    assign obs_l2r   = (sel == 2) ? l2r2  : l2r0;
    assign obs_busy  = (sel == 2) ? busy2 : busy0;
    assign obs_done  = (sel == 2) ? done2 : done0;

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b1; valid0 = 1'b1; valid2 = 1'b1; data = 16'hBEEF; msbf = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        got = {rdy0, busy0, done0, r2l0, l2r0, ser0};
        n_cmp++;
        if (got !== 6'b100000) begin
            n_fail++; $display("FAIL reset_g0: {rdy,busy,done,r2l,l2r,ser}=%b required 100000", got);
        end
        got = {rdy2, busy2, done2, r2l2, l2r2, ser2};
        n_cmp++;
        if (got !== 6'b100000) begin
            n_fail++; $display("FAIL reset_g2: {rdy,busy,done,r2l,l2r,ser}=%b required 100000", got);
        end
        rst = 1'b0; valid0 = 1'b0; valid2 = 1'b0;
        @(negedge clk);
        got = {rdy0, busy0, done0, r2l0, l2r0, ser0};
        n_cmp++;
        if (got !== 6'b100000) begin
            n_fail++; $display("FAIL reset_no_accept_g0: got %b required 100000", got);
        end
        got = {rdy2, busy2, done2, r2l2, l2r2, ser2};
        n_cmp++;
        if (got !== 6'b100000) begin
            n_fail++; $display("FAIL reset_no_accept_g2: got %b required 100000", got);
        end
        $display("reset: done, compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    // Present one word, then check every cycle of the frame against the slot timing model.
    task automatic send_frame(input logic [W-1:0] word, input logic msb, input int which);
        int g, last, waited, k;
        logic exp_slot, exp_bit;
        logic [5:0] got, exp;
        logic [W-1:0] rx;
        sel = which;
        g = (which == 2) ? 2 : 0;
        last = 2 + (W - 1) * (g + 1);
        waited = 0;
        @(negedge clk);
        while (!obs_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (obs_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_wait: InReady=%b required 1 within 100 cycles", obs_ready);
        end
        data = word; msbf = msb;
        if (which == 2) valid2 = 1'b1; else valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0; valid2 = 1'b0;
        data = W'($urandom); msbf = ~msb;
        rx = '0;
        for (int c = 1; c <= last + 1; c++) begin
            if (c > 1) @(negedge clk);
            exp_slot = (c <= last - 1) && (((c - 1) % (g + 1)) == 0);
            k = (c - 1) / (g + 1);
            exp_bit = exp_slot ? (msb ? word[W-1-k] : word[k]) : 1'b0;
            if (c <= last)
                exp = {1'b0, 1'b1, (c == last), exp_slot & msb, exp_slot & ~msb, exp_bit};
            else
                exp = 6'b100000;
            got = {obs_ready, obs_busy, obs_done, obs_r2l, obs_l2r, (c < last) ? obs_ser : 1'b0};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL frame_cycle g=%0d word=%h cyc=%0d: {rdy,busy,done,r2l,l2r,ser}=%b required %b",
                         g, word, c, got, exp);
            end
            if (obs_r2l === 1'b1) rx = {rx[W-2:0], obs_ser};
            if (obs_l2r === 1'b1) rx = {obs_ser, rx[W-1:1]};
        end
        n_cmp++;
        if (rx !== word) begin
            n_fail++; $display("FAIL receiver g=%0d msb=%b: read %h required %h", g, msb, rx, word);
        end
        $display("frame: g=%0d msb=%b word=%h received=%h", g, msb, word, rx);
    endtask

    task automatic test_directed();
        send_frame(16'hA5C3, 1'b1, 0);
        send_frame(16'h8001, 1'b0, 0);
        send_frame(16'hFFFF, 1'b1, 2);
    endtask

    task automatic test_mid_reset();
        logic [4:0] got;
        int stray;
        sel = 0;
        @(negedge clk);
        data = 16'hC0DE; msbf = 1'b1; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        for (int c = 2; c <= 8; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got = {rdy0, busy0, done0, r2l0, l2r0};
        n_cmp++;
        if (got !== 5'b10000) begin
            n_fail++; $display("FAIL mid_reset_ready: {rdy,busy,done,r2l,l2r}=%b required 10000", got);
        end
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (r2l0 || l2r0 || done0 || !rdy0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_fail++; $display("FAIL mid_reset_quiet: %0d active cycles after abort, required 0", stray);
        end
        $display("mid_reset: aborted frame, stray cycles=%0d", stray);
        send_frame(16'h1234, 1'b1, 0);
        send_frame(16'h1234, 1'b0, 0);
    endtask

    // InValid held high with fresh data every cycle: a word is taken once per frame period.
    task automatic test_valid_held();
        localparam int PERIOD = W + 2;
        logic [W-1:0] d_at[0:4*PERIOD];
        logic [W-1:0] rx;
        logic [2:0] got, exp;
        int frames;
        sel = 0;
        frames = 0;
        rx = '0;
        @(negedge clk);
        for (int n = 0; n <= 4 * PERIOD; n++) begin
            if (n > 0) @(negedge clk);
            exp = {(n % PERIOD) == 0, (n % PERIOD) != 0, (n % PERIOD) == PERIOD - 1};
            got = {rdy0, busy0, done0};
            n_cmp++;
            if (got !== exp) begin
                n_fail++; $display("FAIL held_valid n=%0d: {rdy,busy,done}=%b required %b", n, got, exp);
            end
            if (r2l0 === 1'b1) rx = {rx[W-2:0], ser0};
            if (l2r0 === 1'b1) rx = {ser0, rx[W-1:1]};
            if ((n % PERIOD) == PERIOD - 1) begin
                n_cmp++;
                if (rx !== d_at[n - (PERIOD - 1)]) begin
                    n_fail++; $display("FAIL held_word n=%0d: received %h required %h", n, rx, d_at[n - (PERIOD - 1)]);
                end
                frames++;
                $display("held: frame %0d received=%h", frames, rx);
            end
            if ((n % PERIOD) == 0) rx = '0;
            data = W'($urandom); msbf = 1'($urandom); valid0 = 1'b1;
            d_at[n] = data;
        end
        valid0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            send_frame(W'($urandom), 1'($urandom), (i % 2 == 0) ? 0 : 2);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mid_reset();
        test_valid_held();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
